// File: rtl/axi_lite_master_fsm_if.sv
// AXI4-Lite signal bundle between the single-beat master and its bus slave.
// The master modport drives valids/readies toward the slave; the slave modport mirrors it.
interface axi_lite_master_fsm_if #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 64
);
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic                        arvalid;
  logic                        arready;
  logic [2:0]                  arprot;

  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic                        awvalid;
  logic                        awready;
  logic [2:0]                  awprot;

  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;

  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;

  modport master (
    output araddr, arvalid, arprot, rready,
    output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, arprot, rready,
    input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_master_fsm.sv
// Single-beat AXI4-Lite master: runs one AR/R or AW/W/B exchange per start request
// and pulses o_done once per completed beat for the upstream transfer stage.
module axi_lite_master_fsm #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 64
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_start_read,
  input  logic                      i_start_write,
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
  input  logic [AXI_DATA_WIDTH-1:0] i_data,
  output logic                      o_done,
  output logic [AXI_DATA_WIDTH-1:0] o_data,
  output logic                      o_resp_err,
  axi_lite_master_fsm_if.master     bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      aw_pend_q, aw_pend_d;
  logic                      w_pend_q, w_pend_d;

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;

    case (state_q)
      IDLE: begin
        // Write has priority when both requests are raised together.
        if (i_start_write) begin
          addr_d    = i_addr;
          wdata_d   = i_data;
          err_d     = 1'b0;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = WR_REQ;
        end else if (i_start_read) begin
          addr_d  = i_addr;
          err_d   = 1'b0;
          state_d = RD_ADDR;
        end
      end

      RD_ADDR: begin
        if (bus.arready) begin
          state_d = RD_DATA;
        end
      end

      RD_DATA: begin
        if (bus.rvalid) begin
          rdata_d = bus.rdata;
          err_d   = bus.rresp[1];
          state_d = DONE;
        end
      end

      WR_REQ: begin
        // AW and W retire independently; leave once neither is still pending.
        aw_pend_d = aw_pend_q & ~bus.awready;
        w_pend_d  = w_pend_q & ~bus.wready;
        if (!aw_pend_d && !w_pend_d) begin
          state_d = WR_RESP;
        end
      end

      WR_RESP: begin
        if (bus.bvalid) begin
          err_d   = bus.bresp[1];
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every output is a register or a decode of the state register.
  assign bus.arvalid = (state_q == RD_ADDR);
  assign bus.araddr  = addr_q;
  assign bus.arprot  = 3'b000;
  assign bus.rready  = (state_q == RD_DATA);

  assign bus.awvalid = (state_q == WR_REQ) && aw_pend_q;
  assign bus.awaddr  = addr_q;
  assign bus.awprot  = 3'b000;
  assign bus.wvalid  = (state_q == WR_REQ) && w_pend_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = '1;
  assign bus.bready  = (state_q == WR_RESP);

  assign o_done     = (state_q == DONE);
  assign o_resp_err = (state_q == DONE) && err_q;
  assign o_data     = rdata_q;

  // Only the SLVERR/DECERR bit of each response code matters here.
  logic unused_resp_lsb;
  assign unused_resp_lsb = bus.rresp[0] ^ bus.bresp[0];

  a_single_channel: assert property (@(posedge i_clk) disable iff (i_arst)
    !(bus.arvalid && bus.awvalid));

endmodule

// File: doc/axi_lite_master_fsm.md
# axi_lite_master_fsm

Single-beat AXI4-Lite master that executes the word-by-word transfers requested by the cache data-transfer stage. It takes the level start requests, the current beat address and the current write word from that stage, and runs the AR/R or AW/W/B handshakes on the external bus. It returns one `o_done` pulse per completed beat, and the read word for read beats. `o_done` is the per-beat advance strobe that steps the transfer stage's counter, address incrementer and shift register.

## Interface
- `AXI_DATA_WIDTH`, 32: data bus width; `wstrb` width is `AXI_DATA_WIDTH/8`.
- `AXI_ADDR_WIDTH`, 64: address bus width.

Ports:
- `i_clk` in 1: clock; all logic on the rising edge.
- `i_arst` in 1: reset, synchronous, active-high, despite the name.
- `i_start_read` in 1: level; read beats requested while high.
- `i_start_write` in 1: level; write beats requested while high. Wins over read if both are high.
- `i_addr` in `AXI_ADDR_WIDTH`: beat address; sampled at beat launch.
- `i_data` in `AXI_DATA_WIDTH`: write word; sampled at beat launch.
- `o_done` out 1: one-cycle pulse per completed beat.
- `o_data` out `AXI_DATA_WIDTH`: last read word; valid from the `o_done` cycle and held until the next read capture.
- `o_resp_err` out 1: pulses with `o_done` when the response is SLVERR or DECERR.
- Read address channel: `o_araddr` out `AXI_ADDR_WIDTH`, `o_arvalid` out 1, `i_arready` in 1, `o_arprot` out 3.
- Read data channel: `i_rdata` in `AXI_DATA_WIDTH`, `i_rresp` in 2, `i_rvalid` in 1, `o_rready` out 1.
- Write address channel: `o_awaddr` out `AXI_ADDR_WIDTH`, `o_awvalid` out 1, `i_awready` in 1, `o_awprot` out 3.
- Write data channel: `o_wdata` out `AXI_DATA_WIDTH`, `o_wstrb` out `AXI_DATA_WIDTH/8`, `o_wvalid` out 1, `i_wready` in 1.
- Write response channel: `i_bresp` in 2, `i_bvalid` in 1, `o_bready` out 1.

## Operation
- **States:** IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- **IDLE:**
  - If `i_start_write` is high: latch `i_addr` and `i_data`, go to WR_REQ.
  - Else if `i_start_read` is high: latch `i_addr`, go to RD_ADDR.
  - Else stay in IDLE.
- **RD_ADDR:**
  - `o_arvalid` = 1; `o_araddr` = latched address.
  - On `i_arready`, go to RD_DATA.
- **RD_DATA:**
  - `o_rready` = 1.
  - On `i_rvalid`: capture `i_rdata` into `o_data`, set error flag = `i_rresp[1]`, go to DONE.
- **WR_REQ:**
  - `o_awvalid` and `o_wvalid` are raised together on entry.
  - Each one drops independently after its own handshake (`valid & ready`). The two handshakes may complete in either order or in the same cycle.
  - Go to WR_RESP in the cycle the second handshake completes, or when both complete together.
- **WR_RESP:**
  - `o_bready` = 1.
  - On `i_bvalid`: set error flag = `i_bresp[1]`, go to DONE.
- **DONE:**
  - `o_done` = 1 for exactly this cycle; `o_resp_err` = error flag.
  - Always return to IDLE; never launch a beat from DONE.
- **Fixed outputs:** `o_wstrb` is all ones; `o_arprot` = `o_awprot` = 3'b000. `o_wdata` and the address outputs hold their latched values for the whole beat.
- **Start deassert mid-beat:** the beat in flight always completes and `o_done` still pulses (AXI cannot abort a beat).
- **Upstream contract:** the transfer stage updates `i_addr`/`i_data` on `o_done`, then holds start high for the next beat. It must drop start no later than the cycle after the final `o_done`. Start sampled high in IDLE launches a new beat.
- **Bus assumption:** a single outstanding transaction; no IDs, no bursts.

## Timing
- **Reset:**
  - State goes to IDLE.
  - `o_arvalid`, `o_awvalid`, `o_wvalid`, `o_rready`, `o_bready`, `o_done`, `o_resp_err` = 0.
  - `o_data`, `o_araddr`, `o_awaddr`, `o_wdata` = 0.
  - Reset during a beat drops all valids at the next edge. The bus slave must be reset together with this block.
- **All outputs are registered**, or decoded from the state register only; no combinational path from AXI inputs to outputs.
- **Minimum read beat** (ready and valid returned immediately): start sampled at edge 0; `o_arvalid` high in cycle 1; `o_rready` high in cycle 2; `o_done` in cycle 3. Four cycles from IDLE to IDLE.
- **Minimum write beat:** `o_awvalid`/`o_wvalid` in cycle 1; `o_bready` in cycle 2; `o_done` in cycle 3.
- **Stall:** each extra cycle of `ready`/`valid` latency adds exactly one cycle. Valids stay asserted and stable until their handshake (AXI rule).
- **Early response:** `i_bvalid` arriving before both AW and W handshakes is ignored; `o_bready` stays 0 until WR_RESP.
- **Stray inputs:** `i_rvalid` outside RD_DATA is ignored.

## Test plan
- **Read beat, zero-wait slave:** `i_start_read`=1, `i_addr`=0x1000, slave returns 0xDEADBEEF. Expect `o_araddr`=0x1000, then `o_done` exactly 3 cycles after launch with `o_data`=0xDEADBEEF and `o_resp_err`=0.
- **Write beat, W before AW:** `i_wready` in cycle 1, `i_awready` in cycle 3, `i_data`=0x12345678, `i_addr`=0x2004. Expect `o_wvalid` low from cycle 2, `o_awvalid` low from cycle 4, `o_wdata`=0x12345678 stable throughout, `o_wstrb`=0xF, and one `o_done` after `i_bvalid`.
- **Sixteen-beat block read:** start held high and `i_addr` incremented by 4 on each `o_done`. Expect exactly 16 `o_done` pulses, addresses 0x0 to 0x3C in order, and no 17th AR after start drops the cycle following the last pulse.
- **Simultaneous requests:** `i_start_read`=`i_start_write`=1 in IDLE. Expect a write beat (`o_awvalid`=1, `o_arvalid`=0).
- **Error response:** `i_rresp`=2'b10. Expect `o_resp_err`=1 in the same cycle as `o_done`, and 0 on the next beat when the response is OKAY.
- **Reset mid-beat:** `i_arst` asserted while in WR_REQ with `i_awready`=0. Expect all valids and readies 0 at the next edge, state IDLE, and no `o_done`.
